// File: rtl/z16_pkg.sv
// Shared Z16 constants and types used by the fetch unit, its queue and its bus interface.
package z16_pkg;

    localparam int Z16_INSTR_W = 16;
    localparam int Z16_ADDR_W  = 16;
    localparam logic [Z16_ADDR_W-1:0] Z16_PC_STEP = 16'd2;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [Z16_ADDR_W-1:0]  pc;
        logic [Z16_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/z16_fetch_unit_if.sv
// Fetch unit bus: instruction memory, decode handshake, redirect/halt control.
// Z16_FETCH_MISALIGN_TRAP_EN adds the o_misalign status line.
interface z16_fetch_unit_if;
    import z16_pkg::*;

    logic [Z16_ADDR_W-1:0]  o_imem_addr;
    logic [Z16_INSTR_W-1:0] i_imem_instr;
    logic                   o_valid;
    logic [Z16_INSTR_W-1:0] o_instr;
    logic [Z16_ADDR_W-1:0]  o_pc;
    logic                   i_ready;
    logic                   i_redirect;
    logic [Z16_ADDR_W-1:0]  i_redirect_pc;
    logic                   i_halt;
    logic                   o_halted;
`ifdef Z16_FETCH_MISALIGN_TRAP_EN
    logic                   o_misalign;
`endif

    modport master (
`ifdef Z16_FETCH_MISALIGN_TRAP_EN
        output o_misalign,
`endif
        output o_imem_addr, o_valid, o_instr, o_pc, o_halted,
        input  i_imem_instr, i_ready, i_redirect, i_redirect_pc, i_halt
    );

    modport slave (
`ifdef Z16_FETCH_MISALIGN_TRAP_EN
        input  o_misalign,
`endif
        input  o_imem_addr, o_valid, o_instr, o_pc, o_halted,
        output i_imem_instr, i_ready, i_redirect, i_redirect_pc, i_halt
    );

endinterface

// File: rtl/z16_fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush beats push and pop.
// The head is read from registered storage and forced to zero while empty.
module z16_fetch_queue
    import z16_pkg::*;
#(
    parameter  int QUEUE_DEPTH = 2,
    localparam int PTR_W       = $clog2(QUEUE_DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  fetch_entry_t     i_push_entry,
    output logic [CNT_W-1:0] o_count,
    output logic             o_head_valid,
    output fetch_entry_t     o_head_entry
);

    fetch_entry_t     mem_q [QUEUE_DEPTH];
    fetch_entry_t     mem_d [QUEUE_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pop_ok   = i_pop && (count_q != '0);
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) begin
                mem_d[wr_ptr_q] = i_push_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({i_push, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read so stale data never escapes.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_count      = count_q;
    assign o_head_valid = (count_q != '0);
    assign o_head_entry = o_head_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/z16_fetch_unit.sv
// Z16 fetch sequencer: owns the PC, runs the RUN/HALT FSM and feeds the fetch queue.
// Z16_FETCH_MISALIGN_TRAP_EN traps odd redirect targets into HALT instead of aligning them.
module z16_fetch_unit
    import z16_pkg::*;
#(
    parameter logic [Z16_ADDR_W-1:0] RESET_PC    = 16'h0000,
    parameter int                    QUEUE_DEPTH = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    z16_fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_e          state_q, state_d;
    logic [Z16_ADDR_W-1:0] pc_q, pc_d;
    logic                  push, pop, flush;
    logic [CNT_W-1:0]      count;
    logic                  head_valid;
    fetch_entry_t          head_entry, push_entry;
`ifdef Z16_FETCH_MISALIGN_TRAP_EN
    logic                  misalign_q, misalign_d;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
`ifdef Z16_FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        pop        = head_valid & bus.i_ready;
        flush      = bus.i_redirect;
        // A full queue may still accept a fetch when its head leaves this cycle.
        push       = (state_q == RUN) & ~bus.i_halt & ~bus.i_redirect
                   & ((count < CNT_W'(QUEUE_DEPTH)) | pop);
        push_entry = '{pc: pc_q, instr: bus.i_imem_instr};

        if (bus.i_redirect) begin
            state_d = RUN;
            pc_d    = bus.i_redirect_pc & ~16'h0001;
`ifdef Z16_FETCH_MISALIGN_TRAP_EN
            misalign_d = 1'b0;
            if (bus.i_redirect_pc[0]) begin
                state_d    = HALT;
                pc_d       = bus.i_redirect_pc;
                misalign_d = 1'b1;
            end
`endif
        end else begin
            if (push) begin
                pc_d = pc_q + Z16_PC_STEP;
            end
            if ((state_q == RUN) && bus.i_halt) begin
                state_d = HALT;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
`ifdef Z16_FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
`ifdef Z16_FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    z16_fetch_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (push),
        .i_pop        (pop),
        .i_flush      (flush),
        .i_push_entry (push_entry),
        .o_count      (count),
        .o_head_valid (head_valid),
        .o_head_entry (head_entry)
    );

    assign bus.o_imem_addr = pc_q;
    assign bus.o_valid     = head_valid;
    assign bus.o_instr     = head_entry.instr;
    assign bus.o_pc        = head_entry.pc;
    assign bus.o_halted    = (state_q == HALT) && (count == '0);
`ifdef Z16_FETCH_MISALIGN_TRAP_EN
    assign bus.o_misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_z16_fetch_unit.sv
// Bench for z16_fetch_unit: directed vector table, misalign corner sequence and a
// randomized run scored against a queue-based reference model.
module tb_z16_fetch_unit;
    import z16_pkg::*;

    localparam logic [15:0] RESET_PC    = 16'h0000;
    localparam int          QUEUE_DEPTH = 2;
`ifdef Z16_FETCH_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mem_mode = 1'b0;

    always #5 clk = ~clk;

    z16_fetch_unit_if bus ();

    z16_fetch_unit #(
        .RESET_PC    (RESET_PC),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Mode 0 is the small program image; mode 1 gives every address a distinct word.
    function automatic logic [15:0] mem_word(input logic [15:0] addr, input bit mode);
        if (mode) return addr ^ 16'hC3A5;
        case (addr)
            16'h0000: return 16'h004B;
            16'h0002: return 16'h405A;
            default:  return 16'h0000;
        endcase
    endfunction

    always_comb bus.i_imem_instr = mem_word(bus.o_imem_addr, mem_mode);

    // Reference model: an ordered list of fetched entries plus the next fetch address.
    fetch_entry_t m_q[$];
    logic [15:0]  m_pc   = RESET_PC;
    bit           m_run  = 1'b1;
    bit           m_mis  = 1'b0;

    task automatic model_update(input bit r, rd, redir, h, input logic [15:0] rpc);
        if (r) begin
            m_q.delete();
            m_pc  = RESET_PC;
            m_run = 1'b1;
            m_mis = 1'b0;
        end else if (redir) begin
            m_q.delete();
            if (MIS_EN && rpc[0]) begin
                m_run = 1'b0;
                m_pc  = rpc;
                m_mis = 1'b1;
            end else begin
                m_run = 1'b1;
                m_pc  = rpc & 16'hFFFE;
                m_mis = 1'b0;
            end
        end else begin
            if (rd && m_q.size() > 0) void'(m_q.pop_front());
            if (m_run && !h && m_q.size() < QUEUE_DEPTH) begin
                m_q.push_back('{pc: m_pc, instr: mem_word(m_pc, mem_mode)});
                m_pc = m_pc + 16'd2;
            end
            if (m_run && h) m_run = 1'b0;
        end
    endtask

    function automatic logic [63:0] model_vec();
        fetch_entry_t head;
        head = (m_q.size() > 0) ? m_q[0] : '0;
        return {14'd0, m_q.size() > 0, (!m_run && m_q.size() == 0), head.pc, head.instr, m_pc};
    endfunction

    function automatic logic [63:0] dut_vec();
        return {14'd0, bus.o_valid, bus.o_halted, bus.o_pc, bus.o_instr, bus.o_imem_addr};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (valid,halted,pc,instr,addr)", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, return at the next falling edge.
    task automatic step(input bit r, rd, redir, h, input logic [15:0] rpc);
        rst               = r;
        bus.i_ready       = rd;
        bus.i_redirect    = redir;
        bus.i_halt        = h;
        bus.i_redirect_pc = rpc;
        @(posedge clk);
        model_update(r, rd, redir, h, rpc);
        @(negedge clk);
    endtask

    typedef struct {
        bit          rst, ready, redir, halt;
        logic [15:0] rpc;
        bit          v, hl;
        logic [15:0] pc, instr, addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, rd, rdr, h, input logic [15:0] rpc,
                       input bit v, hl, input logic [15:0] pc, ins, addr);
        vecs.push_back('{r, rd, rdr, h, rpc, v, hl, pc, ins, addr});
    endtask

    initial begin
        rst               = 1'b1;
        bus.i_ready       = 1'b0;
        bus.i_redirect    = 1'b0;
        bus.i_halt        = 1'b0;
        bus.i_redirect_pc = 16'h0000;

        //   rst rdy rdr hlt rpc        v  hl pc       instr    addr
        add(1, 1, 0, 0, 16'h0000,   0, 0, 16'h0000, 16'h0000, 16'h0000);
        add(0, 1, 0, 0, 16'h0000,   1, 0, 16'h0000, 16'h004B, 16'h0002);
        add(0, 1, 0, 0, 16'h0000,   1, 0, 16'h0002, 16'h405A, 16'h0004);
        add(0, 1, 0, 0, 16'h0000,   1, 0, 16'h0004, 16'h0000, 16'h0006);
        add(1, 0, 0, 0, 16'h0000,   0, 0, 16'h0000, 16'h0000, 16'h0000);
        add(0, 0, 0, 0, 16'h0000,   1, 0, 16'h0000, 16'h004B, 16'h0002);
        add(0, 0, 0, 0, 16'h0000,   1, 0, 16'h0000, 16'h004B, 16'h0004);
        add(0, 0, 0, 0, 16'h0000,   1, 0, 16'h0000, 16'h004B, 16'h0004);
        add(0, 0, 0, 0, 16'h0000,   1, 0, 16'h0000, 16'h004B, 16'h0004);
        add(0, 0, 0, 0, 16'h0000,   1, 0, 16'h0000, 16'h004B, 16'h0004);
        add(0, 1, 0, 0, 16'h0000,   1, 0, 16'h0002, 16'h405A, 16'h0006);
        add(0, 1, 0, 0, 16'h0000,   1, 0, 16'h0004, 16'h0000, 16'h0008);
        add(0, 1, 0, 0, 16'h0000,   1, 0, 16'h0006, 16'h0000, 16'h000A);
        add(0, 1, 1, 0, 16'h0002,   0, 0, 16'h0000, 16'h0000, 16'h0002);
        add(0, 1, 0, 0, 16'h0000,   1, 0, 16'h0002, 16'h405A, 16'h0004);
        add(0, 1, 0, 0, 16'h0000,   1, 0, 16'h0004, 16'h0000, 16'h0006);
        add(0, 1, 1, 0, 16'hFFFE,   0, 0, 16'h0000, 16'h0000, 16'hFFFE);
        add(0, 1, 0, 0, 16'h0000,   1, 0, 16'hFFFE, 16'h0000, 16'h0000);
        add(0, 1, 0, 0, 16'h0000,   1, 0, 16'h0000, 16'h004B, 16'h0002);
        add(0, 0, 0, 0, 16'h0000,   1, 0, 16'h0000, 16'h004B, 16'h0004);
        add(0, 0, 0, 1, 16'h0000,   1, 0, 16'h0000, 16'h004B, 16'h0004);
        add(0, 1, 0, 0, 16'h0000,   1, 0, 16'h0002, 16'h405A, 16'h0004);
        add(0, 1, 0, 0, 16'h0000,   0, 1, 16'h0000, 16'h0000, 16'h0004);
        add(0, 1, 0, 1, 16'h0000,   0, 1, 16'h0000, 16'h0000, 16'h0004);
        add(0, 1, 1, 0, 16'h0000,   0, 0, 16'h0000, 16'h0000, 16'h0000);
        add(0, 1, 0, 0, 16'h0000,   1, 0, 16'h0000, 16'h004B, 16'h0002);
        add(0, 0, 0, 0, 16'h0000,   1, 0, 16'h0000, 16'h004B, 16'h0004);
        add(0, 0, 0, 0, 16'h0000,   1, 0, 16'h0000, 16'h004B, 16'h0004);
        add(1, 1, 1, 1, 16'h0040,   0, 0, 16'h0000, 16'h0000, 16'h0000);
        add(0, 1, 0, 0, 16'h0000,   1, 0, 16'h0000, 16'h004B, 16'h0002);
        add(0, 1, 1, 1, 16'h0000,   0, 0, 16'h0000, 16'h0000, 16'h0000);
        add(0, 1, 0, 0, 16'h0000,   1, 0, 16'h0000, 16'h004B, 16'h0002);
        add(0, 1, 0, 1, 16'h0000,   0, 1, 16'h0000, 16'h0000, 16'h0002);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ready, vecs[i].redir, vecs[i].halt, vecs[i].rpc);
            check($sformatf("vec%0d", i), dut_vec(),
                  {14'd0, vecs[i].v, vecs[i].hl, vecs[i].pc, vecs[i].instr, vecs[i].addr});
        end

        // Odd redirect target: traps into HALT when enabled, otherwise bit 0 is dropped.
        step(1, 0, 0, 0, 16'h0000);
        step(0, 1, 1, 0, 16'h0003);
`ifdef Z16_FETCH_MISALIGN_TRAP_EN
        check("mis_set", {63'd0, bus.o_misalign}, 64'd1);
        check("mis_halt", dut_vec(), {14'd0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0003});
        step(0, 1, 0, 0, 16'h0000);
        check("mis_hold", {63'd0, bus.o_misalign}, 64'd1);
        check("mis_nofetch", dut_vec(), {14'd0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0003});
        step(0, 1, 1, 0, 16'h0002);
        check("mis_clear", {63'd0, bus.o_misalign}, 64'd0);
        step(0, 1, 0, 0, 16'h0000);
        check("mis_resume", dut_vec(), {14'd0, 1'b1, 1'b0, 16'h0002, 16'h405A, 16'h0004});
`else
        check("odd_redir", dut_vec(), {14'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0002});
        step(0, 1, 0, 0, 16'h0000);
        check("odd_target", dut_vec(), {14'd0, 1'b1, 1'b0, 16'h0002, 16'h405A, 16'h0004});
`endif

        mem_mode = 1'b1;
        step(1, 0, 0, 0, 16'h0000);
        for (int c = 0; c < 3000; c++) begin
            bit          r, rd, rdr, h;
            logic [15:0] rpc;
            r   = ($urandom_range(0, 199) == 0);
            rd  = ($urandom_range(0, 3) != 0);
            rdr = ($urandom_range(0, 15) == 0);
            h   = ($urandom_range(0, 19) == 0);
            rpc = 16'($urandom);
            step(r, rd, rdr, h, rpc);
            check($sformatf("rand%0d", c), dut_vec(), model_vec());
`ifdef Z16_FETCH_MISALIGN_TRAP_EN
            check($sformatf("rand_mis%0d", c), {63'd0, bus.o_misalign}, {63'd0, m_mis});
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/z16_fetch_unit.md
Name: z16_fetch_unit

Overview:
Instruction fetch sequencer for the Z16 core. Owns the program counter and drives the address of the combinational instruction memory, which returns its word in the same cycle. Buffers fetched words in a small queue and hands {pc, instr} to decode over a valid/ready handshake. Handles branch redirects and halt.

Parameters:
RESET_PC, 16'h0000, byte address fetched first after reset; bit 0 must be 0.
QUEUE_DEPTH, 2, fetch queue entries; power of two, minimum 2.

Ports:
i_clk  input  1  core clock
i_rst  input  1  synchronous, active-high reset
o_imem_addr  output  16  byte address to instruction memory; equals pc_q
i_imem_instr  input  16  instruction word returned combinationally for o_imem_addr
o_valid  output  1  queue head is valid
o_instr  output  16  head instruction
o_pc  output  16  byte address of head instruction
i_ready  input  1  decode accepts head this cycle
i_redirect  input  1  branch/jump taken; flush and refetch
i_redirect_pc  input  16  redirect target byte address
i_halt  input  1  stop fetching (level, sampled each cycle)
o_halted  output  1  state is HALT and queue empty

Behaviour:
- One clock; reset is synchronous and active-high. Everything below is sampled on rising i_clk.
- Reset: pc_q=RESET_PC, queue empty, state=RUN, o_valid=0, o_instr=0, o_pc=0, o_halted=0.
- States: RUN (fetching), HALT (not fetching). RUN->HALT when i_halt=1 and i_redirect=0. HALT->RUN only on i_redirect=1. i_halt has no effect in HALT.
- pop = o_valid & i_ready. push = (state==RUN) & ~i_halt & ~i_redirect & (count<QUEUE_DEPTH | pop).
- On push: enqueue {pc_q, i_imem_instr}; pc_q <= pc_q+2, modulo 2^16 (0xFFFE wraps to 0x0000).
- Full queue with simultaneous pop: push and pop both occur; count is unchanged.
- o_valid = (count!=0); o_instr/o_pc are the head entry, registered (no combinational path from i_imem_instr). When empty, o_instr and o_pc hold 0.
- Latency: first fetch occurs in the cycle after reset deasserts; o_valid=1 with o_pc=RESET_PC one cycle later. Steady state is one instruction per cycle while i_ready=1.
- Redirect has priority over everything.
  - Queue flushed; a same-cycle pop is discarded with the flush, and decode treats it as squashed.
  - pc_q <= {i_redirect_pc[15:1],1'b0}; state=RUN; no push that cycle.
  - Timing: redirect in cycle N gives o_valid=0 in N+1; the target instruction is at the head with o_valid=1 in N+2.
- Halt:
  - Fetching stops in the same cycle i_halt is seen; no push that cycle.
  - Queued entries keep draining normally.
  - o_halted=1 when state==HALT and count==0.
  - pc_q holds the address of the next unfetched instruction.
- Reset mid-operation overrides redirect, halt and the handshake: queue cleared, pc_q=RESET_PC.
- i_ready while o_valid=0 is ignored.

Optional Feature:
Z16_FETCH_MISALIGN_TRAP_EN
- Defined: adds output o_misalign (1 bit, reset 0).
  - A redirect with i_redirect_pc[0]=1 sets o_misalign, flushes the queue and enters HALT with pc_q = i_redirect_pc unmodified.
  - o_misalign stays set until reset or the next aligned redirect.
- Undefined: the port is absent and bit 0 is silently cleared as above.

Decomposition:
- Shared package z16_pkg:
  - constants Z16_INSTR_W=16, Z16_ADDR_W=16, Z16_PC_STEP=2;
  - the fetch state enum {RUN, HALT};
  - a packed fetch-entry typedef {pc[15:0], instr[15:0]}.
- One sub-module, z16_fetch_queue: synchronous FIFO parameterised by QUEUE_DEPTH.
  - Signals: push/pop/flush, count, head outputs.
  - Flush has priority over push and pop.
- Top level holds pc_q, the RUN/HALT FSM and push/redirect logic.

Test Plan:
- Memory model 0x0000=0x004B, 0x0002=0x405A, rest 0x0000. Reset then i_ready=1 -> cycle 2: o_pc=0x0000, o_instr=0x004B; cycle 3: o_pc=0x0002, o_instr=0x405A; o_pc steps by 2 each cycle.
- Hold i_ready=0 for 5 cycles -> count saturates at 2, pc_q stops at 0x0004, o_pc stays 0x0000. Release -> 0x0000, 0x0002, 0x0004 in order, none lost or duplicated.
- Redirect to 0x0002 while the head is at 0x0006, with i_ready=1 -> next cycle o_valid=0; following cycle o_pc=0x0002, o_instr=0x405A; no 0x0006/0x0008 entries emerge.
- Redirect to 0xFFFE -> heads 0xFFFE then 0x0000 (wrap).
- Assert i_halt with 2 queued -> both drain, then o_halted=1, o_valid=0. A later redirect to 0x0000 -> o_halted=0, 0x004B valid two cycles later.
- Assert i_rst mid-stream with the queue full -> next cycle o_valid=0, o_imem_addr=0x0000. With the macro defined, redirect to 0x0003 -> o_misalign=1, o_halted=1.
